sprite_blitter: RTL and testbench

SPRITE_BLITTER -- requirements
Module: sprite_blitter

---
 rtl/sprite_blitter.sv | 100 ++++++++++
 tb/tb_sprite_blitter.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/sprite_blitter.sv
// sprite_blitter: streams NUM_SLOTS ROM sprites side by side into a VGA write port.
// Define BLIT_TRANSPARENT_EN to suppress plots of background (rom_q=1) pixels.
module sprite_blitter #(
    parameter int SPRITE_W  = 80,
    parameter int SPRITE_H  = 120,
    parameter int NUM_SLOTS = 2,
    parameter int ADDR_W    = 14
) (
    input  logic                   CLOCK_50,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic [2*NUM_SLOTS-1:0] choice,
    input  logic [2:0]             fg_colour,
    input  logic [3*NUM_SLOTS-1:0] bg_colour,
    input  logic                   rom_q,
    output logic [ADDR_W-1:0]      rom_addr,
    output logic [1:0]             rom_sel,
    output logic [7:0]             x,
    output logic [6:0]             y,
    output logic [2:0]             colour,
    output logic                   plot,
    output logic                   busy,
    output logic                   done
);
    typedef enum logic [1:0] {IDLE, DRAW, FLUSH} state_t;
    localparam logic [7:0] COL_MAX  = 8'(SPRITE_W - 1);
    localparam logic [6:0] ROW_MAX  = 7'(SPRITE_H - 1);
    localparam logic [7:0] SLOT_MAX = 8'(NUM_SLOTS - 1);
    localparam logic [7:0] X_STEP   = 8'(SPRITE_W);
    state_t state, state_nx;
    logic [7:0] col, slot, xbase, slot_d;
    logic [6:0] row;
    logic [2*NUM_SLOTS-1:0] choice_l;
    logic [3*NUM_SLOTS-1:0] bg_l;
    logic [2:0] fg_l, bg_sel;
    logic [1:0] ch;
    logic pend, last_col, last_row, last_slot;
    assign last_col  = col == COL_MAX;
    assign last_row  = row == ROW_MAX;
    assign last_slot = slot == SLOT_MAX;
    assign ch        = 2'(choice_l >> (2 * slot));
    assign rom_sel   = ch == 2'd3 ? 2'd2 : ch;
    assign bg_sel    = 3'(bg_l >> (3 * slot_d));
    assign busy      = state != IDLE;
`ifdef BLIT_TRANSPARENT_EN
    assign plot      = pend & ~rom_q;
`else
    assign plot      = pend;
`endif
    assign colour    = plot ? (rom_q ? bg_sel : fg_l) : 3'd0;
    always_comb begin
        state_nx = state;
        state_nx = (state == IDLE && start) ? DRAW :
                   (state == DRAW && last_col && last_row && last_slot) ? FLUSH :
                   (state == FLUSH) ? IDLE : state;
    end
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            col      <= '0;
            row      <= '0;
            slot     <= '0;
            xbase    <= '0;
            slot_d   <= '0;
            rom_addr <= '0;
            choice_l <= '0;
            bg_l     <= '0;
            fg_l     <= '0;
            pend     <= 1'b0;
            done     <= 1'b0;
            x        <= '0;
            y        <= '0;
        end else begin
            state  <= state_nx;
            done   <= state == FLUSH;
            pend   <= state == DRAW;
            x      <= xbase + col;
            y      <= row;
            slot_d <= slot;
            if (state == IDLE && start) begin
                choice_l <= choice;
                fg_l     <= fg_colour;
                bg_l     <= bg_colour;
            end
            // Counters wrap back to zero after the last pixel, ready for the next frame.
            if (state == DRAW) begin
                col <= last_col ? 8'd0 : col + 8'd1;
                if (last_col)
                    row <= last_row ? 7'd0 : row + 7'd1;
                if (last_col && last_row) begin
                    slot     <= last_slot ? 8'd0 : slot + 8'd1;
                    xbase    <= last_slot ? 8'd0 : xbase + X_STEP;
                    rom_addr <= '0;
                end else begin
                    rom_addr <= rom_addr + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_sprite_blitter.sv
// tb_sprite_blitter: directed checks of sprite_blitter with a 4x2 sprite, two slots.
module tb_sprite_blitter;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] choice = '0;
    logic [2:0] fg_colour = '0;
    logic [5:0] bg_colour = '0;
    logic       rom_q = 1'b0;
    logic       rom_mode = 1'b0;
    logic [2:0] rom_addr;
    logic [1:0] rom_sel;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot, busy, done;
    int n_chk = 0;
    int n_fail = 0;
`ifdef BLIT_TRANSPARENT_EN
    localparam bit TRANSP = 1'b1;
`else
    localparam bit TRANSP = 1'b0;
`endif

    sprite_blitter #(.SPRITE_W(4), .SPRITE_H(2), .NUM_SLOTS(2), .ADDR_W(3)) dut (
        .CLOCK_50(clk), .reset_n(reset_n), .start(start), .choice(choice),
        .fg_colour(fg_colour), .bg_colour(bg_colour), .rom_q(rom_q),
        .rom_addr(rom_addr), .rom_sel(rom_sel), .x(x), .y(y), .colour(colour),
        .plot(plot), .busy(busy), .done(done)
    );

    always #10 clk = ~clk;
    always @(posedge clk) rom_q <= rom_mode ? 1'b1 : rom_addr[0];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_x"}, x, 0);
        check({tag, "_y"}, y, 0);
        check({tag, "_colour"}, colour, 0);
        check({tag, "_plot"}, plot, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_addr"}, rom_addr, 0);
        check({tag, "_sel"}, rom_sel, 0);
    endtask

    task automatic run_frame(input logic [3:0] ch, input logic [2:0] fg, input logic [5:0] bg,
                             input bit restart);
        int np, ne, nd, sl, rw, cl, idx;
        logic [1:0] es;
        logic eq, ep;
        @(negedge clk);
        choice = ch; fg_colour = fg; bg_colour = bg; start = 1'b1;
        @(negedge clk);
        start = 1'b0; choice = ~ch; fg_colour = ~fg; bg_colour = ~bg;
        np = 0; ne = 0; nd = 0;
        for (int k = 0; k <= 20; k++) begin
            if (k > 0) @(negedge clk);
            if (restart) start = (k == 2 || k == 7);
            if (k < 16) begin
                sl = k / 8;
                es = ch[2*sl +: 2];
                if (es == 2'd3) es = 2'd2;
                check("rom_addr", rom_addr, k % 8);
                check("rom_sel", rom_sel, es);
            end
            if (k >= 1 && k <= 16) begin
                idx = k - 1; sl = idx / 8; rw = (idx % 8) / 4; cl = idx % 4;
                eq = rom_mode | (cl % 2 == 1);
                ep = !(TRANSP && eq);
                if (ep) ne++;
                check("plot", plot, ep);
                if (plot) begin
                    check("x", x, sl * 4 + cl);
                    check("y", y, rw);
                    check("colour", colour, eq ? bg[3*sl +: 3] : fg);
                end
            end else begin
                check("plot_off", plot, 0);
            end
            check("busy", busy, k <= 16);
            check("done", done, k == 17);
            if (plot) np++;
            if (done) nd++;
        end
        start = 1'b0;
        check("plot_count", np, ne);
        check("done_count", nd, 1);
    endtask

    initial begin
        int acc, fp, nd;
        logic prev_busy;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        reset_n = 1'b1;
        rom_mode = 1'b0;
        run_frame(4'b1001, 3'b010, {3'b000, 3'b111}, 1'b0);
        run_frame(4'b0011, 3'b101, {3'b011, 3'b100}, 1'b1);
        rom_mode = 1'b1;
        run_frame(4'b1110, 3'b001, {3'b110, 3'b011}, 1'b0);
        rom_mode = 1'b0;
        @(negedge clk);
        choice = 4'b1001; fg_colour = 3'b010; bg_colour = 6'b000111; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_all_zero("midreset");
        @(negedge clk);
        reset_n = 1'b1;
        fp = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (plot) fp++;
        end
        check("post_reset_plots", fp, 0);
        check("post_reset_busy", busy, 0);
        @(negedge clk);
        start = 1'b1;
        prev_busy = 1'b0; acc = 0; fp = 0; nd = 0;
        for (int k = 0; k < 56; k++) begin
            @(negedge clk);
            if (busy && !prev_busy) acc = k;
            if (plot) fp++;
            if (done) begin
                check("hold_done_latency", k - acc, 17);
                check("hold_plots", fp, 16);
                fp = 0;
                nd++;
            end
            prev_busy = busy;
        end
        start = 1'b0;
        check("hold_frames", nd, 3);
        for (int i = 0; i < 40 && busy; i++) @(negedge clk);
        check("drain_busy", busy, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
